// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer.
// Covers FSM states, CONTROL bit positions and STATUS layout.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUT
  } state_t;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int NTAPS           = 9;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate: unsigned pixel times signed coefficient.
// Clear has priority over enable; the sum wraps at ACC_W bits.
module conv_mac #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [7:0]       i_pix,
  input  logic [7:0]       i_coef,
  output logic [ACC_W-1:0] o_acc
);

  logic [16:0] w_px;
  logic [16:0] w_cf;
  logic [16:0] w_prod;
  logic [ACC_W-1:0] r_acc;

  // Low 17 bits of the product are exact for 9b x 8b signed.
  assign w_px   = {9'b0, i_pix};
  assign w_cf   = {{9{i_coef[7]}}, i_coef};
  assign w_prod = w_px * w_cf;
  assign o_acc  = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + {{(ACC_W-17){w_prod[16]}}, w_prod};
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Walks every 3x3 window of the image buffer, feeds the MAC,
// and hands each sum out over a valid/ready port.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int ACC_W = 32,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_wr,
  input  logic [31:0]      ctrl_data,
  input  logic [31:0]      filter1,
  input  logic [31:0]      filter2,
  input  logic [31:0]      filter3,
  output logic             img_rd_en,
  output logic [AW-1:0]    img_rd_addr,
  input  logic [7:0]       img_rd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [15:0]      res_idx,
  output logic             busy,
  output logic             done,
  output logic [31:0]      status
);

  state_t r_state, w_state_nxt;
  logic [3:0]  r_tap, w_tap_nxt;
  logic [15:0] r_orow, w_orow_nxt;
  logic [15:0] r_ocol, w_ocol_nxt;
  logic [15:0] r_idx, w_idx_nxt;
  logic        r_done, w_done_nxt;
  logic        r_rd_en, r_valid;
  logic [AW-1:0] r_addr;
  logic        r_mac_en;
  logic [3:0]  r_mac_k;
  logic        w_clr, w_start, w_abort, w_acc, w_last;
  logic [71:0] w_cvec;
  logic [7:0]  w_coef;
  int          w_ky, w_kx, w_a;
  logic        w_unused;

  assign w_start = ctrl_wr & ctrl_data[CTRL_START_BIT]
                 & ~ctrl_data[CTRL_ABORT_BIT];
  assign w_abort = ctrl_wr & ctrl_data[CTRL_ABORT_BIT];
  assign w_acc   = r_valid & res_ready;
  assign w_last  = (r_orow == 16'(IMG_H-3))
                 && (r_ocol == 16'(IMG_W-3));
  assign w_cvec  = {filter3[7:0], filter2, filter1};
  assign w_unused = ^{filter3[31:8], ctrl_data[31:2]};

  always_comb begin
    w_coef = w_cvec[7:0];
    for (int k = 0; k < NTAPS; k++) begin
      if (r_mac_k == 4'(k)) w_coef = w_cvec[k*8 +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_tap;
    w_orow_nxt  = r_orow;
    w_ocol_nxt  = r_ocol;
    w_idx_nxt   = r_idx;
    w_done_nxt  = r_done;
    w_clr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_FETCH;
          w_tap_nxt   = '0;
          w_orow_nxt  = '0;
          w_ocol_nxt  = '0;
          w_idx_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_clr       = 1'b1;
        end
      end
      S_FETCH: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end else if (r_tap == 4'(NTAPS-1)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_tap_nxt = r_tap + 4'd1;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_OUT;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end
      end
      S_OUT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end else if (w_acc && w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = S_FETCH;
          w_tap_nxt   = '0;
          w_idx_nxt   = r_idx + 16'd1;
          w_clr       = 1'b1;
          if (r_ocol == 16'(IMG_W-3)) begin
            w_ocol_nxt = '0;
            w_orow_nxt = r_orow + 16'd1;
          end else begin
            w_ocol_nxt = r_ocol + 16'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address of the tap that will be read next cycle.
  always_comb begin
    w_ky = int'(w_tap_nxt) / 3;
    w_kx = int'(w_tap_nxt) % 3;
    w_a  = (int'(w_orow_nxt) + w_ky) * IMG_W
         + int'(w_ocol_nxt) + w_kx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_tap    <= '0;
      r_orow   <= '0;
      r_ocol   <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_addr   <= '0;
      r_valid  <= 1'b0;
      r_mac_en <= 1'b0;
      r_mac_k  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tap    <= w_tap_nxt;
      r_orow   <= w_orow_nxt;
      r_ocol   <= w_ocol_nxt;
      r_idx    <= w_idx_nxt;
      r_done   <= w_done_nxt;
      r_rd_en  <= (w_state_nxt == S_FETCH);
      r_valid  <= (w_state_nxt == S_OUT);
      if (w_state_nxt == S_FETCH) r_addr <= AW'(w_a);
      // Data of a tap returns one cycle after its read.
      r_mac_en <= (r_state == S_FETCH) && !w_abort;
      r_mac_k  <= r_tap;
    end
  end

  conv_mac #(.ACC_W(ACC_W)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (r_mac_en),
    .i_pix  (img_rd_data),
    .i_coef (w_coef),
    .o_acc  (res_data)
  );

  assign img_rd_en   = r_rd_en;
  assign img_rd_addr = r_addr;
  assign res_valid   = r_valid;
  assign res_idx     = r_idx;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

  always_comb begin
    status = '0;
    status[STATUS_BUSY_BIT] = busy;
    status[STATUS_DONE_BIT] = r_done;
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomized bench for conv_seq_ctrl against a direct
// windowed-sum reference over a modelled image buffer.
module tb_conv_seq_ctrl;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NRES = (W-2)*(H-2);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_wr;
  logic [31:0] ctrl_data;
  logic [31:0] filter1, filter2, filter3;
  logic        img_rd_en;
  logic [5:0]  img_rd_addr;
  logic [7:0]  img_rd_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [15:0] res_idx;
  logic        busy, done;
  logic [31:0] status;

  conv_seq_ctrl #(.IMG_W(W), .IMG_H(H), .ACC_W(32), .AW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_wr(ctrl_wr), .ctrl_data(ctrl_data),
    .filter1(filter1), .filter2(filter2), .filter3(filter3),
    .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr),
    .img_rd_data(img_rd_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [W*H];
  always @(posedge clk) if (img_rd_en) img_rd_data <= mem[img_rd_addr];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q_data[$];
  int          q_idx[$];
  int          first_c, done_c;

  function automatic logic [31:0] model(input int idx);
    int orow, ocol, s;
    logic [71:0] cv;
    byte cf;
    orow = idx / (W-2);
    ocol = idx % (W-2);
    cv = {filter3[7:0], filter2, filter1};
    s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) begin
        cf = cv[(ky*3+kx)*8 +: 8];
        s += int'(mem[(orow+ky)*W + ocol+kx]) * int'(cf);
      end
    return s;
  endfunction

  task automatic do_start();
    @(negedge clk);
    ctrl_data = 32'h1;
    ctrl_wr   = 1'b1;
    @(negedge clk);
    ctrl_wr   = 1'b0;
    ctrl_data = 32'h0;
  endtask

  // Cycle c = edges since the start was sampled.
  task automatic collect(input int mode, input int restart_at);
    int c, stall;
    logic pv, pacc;
    logic [31:0] pd;
    logic [15:0] pi;
    bit rdy;
    c = 1; stall = 0; pv = 0; pacc = 0; pd = 0; pi = 0;
    q_data.delete(); q_idx.delete();
    first_c = -1; done_c = -1;
    while (c < 2000) begin
      if (res_valid === 1'b1 && first_c < 0) first_c = c;
      if (pv && !pacc) begin
        n_tests++;
        if (res_valid !== 1'b1 || res_data !== pd || res_idx !== pi) begin
          n_fail++;
          $display("FAIL hold c=%0d got v=%b d=%h i=%0d required v=1 d=%h i=%0d",
                   c, res_valid, res_data, res_idx, pd, pi);
        end
      end
      if (done === 1'b1 && busy === 1'b0) begin
        done_c = c;
        break;
      end
      ctrl_wr   = (c == restart_at);
      ctrl_data = (c == restart_at) ? 32'h1 : 32'h0;
      if (mode == 0) rdy = 1'b1;
      else if (q_data.size() == 5 && res_valid && stall < 20) begin
        rdy = 1'b0;
        stall++;
      end else rdy = 1'($urandom_range(0, 1));
      res_ready = rdy;
      pv = res_valid; pd = res_data; pi = res_idx;
      pacc = res_valid && rdy;
      if (pacc) begin
        q_data.push_back(res_data);
        q_idx.push_back(int'(res_idx));
      end
      @(negedge clk);
      c++;
    end
    ctrl_wr = 1'b0;
    res_ready = 1'b0;
    n_tests++;
    if (done_c < 0) begin
      n_fail++;
      $display("FAIL timeout got no done after %0d cycles required done", c);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({img_rd_en, img_rd_addr, res_valid, res_data, res_idx,
         busy, done, status} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got en=%b a=%0d v=%b d=%h i=%0d b=%b dn=%b s=%h required all 0",
               img_rd_en, img_rd_addr, res_valid, res_data, res_idx,
               busy, done, status);
    end
  endtask

  task automatic test_ones();
    foreach (mem[i]) mem[i] = 8'd1;
    filter1 = 32'h01010101;
    filter2 = 32'h01010101;
    filter3 = {$urandom_range(0, 32'hFFFFFF)} << 8 | 32'h01;
    do_start();
    n_tests++;
    if (busy !== 1'b1 || img_rd_en !== 1'b1 || img_rd_addr !== 6'd0
        || status !== 32'h1) begin
      n_fail++;
      $display("FAIL ones_t1 got b=%b en=%b a=%0d s=%h required 1 1 0 1",
               busy, img_rd_en, img_rd_addr, status);
    end
    collect(0, -1);
    n_tests++;
    if (first_c != 11 || done_c != 397) begin
      n_fail++;
      $display("FAIL ones_timing got valid@%0d done@%0d required 11 397",
               first_c, done_c);
    end
    n_tests++;
    if (q_data.size() != NRES || status !== 32'h2) begin
      n_fail++;
      $display("FAIL ones_count got %0d s=%h required %0d s=2",
               q_data.size(), status, NRES);
    end
    foreach (q_data[i]) begin
      n_tests++;
      if (q_data[i] !== 32'd9 || q_idx[i] != i) begin
        n_fail++;
        $display("FAIL ones_res got d=%h i=%0d required d=9 i=%0d",
                 q_data[i], q_idx[i], i);
      end
    end
  endtask

  task automatic test_ramp();
    foreach (mem[i]) mem[i] = 8'(i);
    filter1 = 32'h0;
    filter2 = 32'h00000001;
    filter3 = 32'h0;
    do_start();
    collect(0, -1);
    n_tests++;
    if (q_data.size() != NRES) begin
      n_fail++;
      $display("FAIL ramp_count got %0d required %0d", q_data.size(), NRES);
    end else begin
      n_tests++;
      if (q_data[0] !== 32'd9 || q_data[35] !== 32'd54) begin
        n_fail++;
        $display("FAIL ramp_ends got %0d %0d required 9 54",
                 q_data[0], q_data[35]);
      end
    end
    foreach (q_data[i]) begin
      n_tests++;
      if (q_data[i] !== model(i) || q_idx[i] != i) begin
        n_fail++;
        $display("FAIL ramp_res got d=%h i=%0d required d=%h i=%0d",
                 q_data[i], q_idx[i], model(i), i);
      end
    end
  endtask

  task automatic test_negative();
    foreach (mem[i]) mem[i] = 8'hFF;
    filter1 = 32'hFFFFFFFF;
    filter2 = 32'hFFFFFFFF;
    filter3 = 32'h000000FF;
    do_start();
    collect(0, -1);
    n_tests++;
    if (q_data.size() != NRES) begin
      n_fail++;
      $display("FAIL neg_count got %0d required %0d", q_data.size(), NRES);
    end
    foreach (q_data[i]) begin
      n_tests++;
      if (q_data[i] !== 32'hFFFFF709) begin
        n_fail++;
        $display("FAIL neg_res i=%0d got %h required fffff709", i, q_data[i]);
      end
    end
  endtask

  task automatic test_restart_busy();
    foreach (mem[i]) mem[i] = 8'($urandom);
    filter1 = $urandom; filter2 = $urandom; filter3 = $urandom;
    do_start();
    collect(0, 30);
    n_tests++;
    if (q_data.size() != NRES || done_c != 397) begin
      n_fail++;
      $display("FAIL restart_busy got n=%0d done@%0d required %0d 397",
               q_data.size(), done_c, NRES);
    end
    foreach (q_data[i]) begin
      n_tests++;
      if (q_data[i] !== model(i) || q_idx[i] != i) begin
        n_fail++;
        $display("FAIL restart_res got d=%h i=%0d required d=%h i=%0d",
                 q_data[i], q_idx[i], model(i), i);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    foreach (mem[i]) mem[i] = 8'($urandom);
    filter1 = $urandom; filter2 = $urandom; filter3 = $urandom;
    do_start();
    collect(1, -1);
    n_tests++;
    if (q_data.size() != NRES) begin
      n_fail++;
      $display("FAIL stall_count got %0d required %0d", q_data.size(), NRES);
    end
    foreach (q_data[i]) begin
      n_tests++;
      if (q_data[i] !== model(i) || q_idx[i] != i) begin
        n_fail++;
        $display("FAIL stall_res got d=%h i=%0d required d=%h i=%0d",
                 q_data[i], q_idx[i], model(i), i);
      end
    end
  endtask

  task automatic test_abort();
    int c, nacc, bad;
    foreach (mem[i]) mem[i] = 8'($urandom);
    filter1 = $urandom; filter2 = $urandom; filter3 = $urandom;
    do_start();
    res_ready = 1'b1;
    c = 1; nacc = 0;
    while (c < 114) begin
      if (res_valid === 1'b1) nacc++;
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (nacc != 10 || img_rd_en !== 1'b1 || res_idx !== 16'd10) begin
      n_fail++;
      $display("FAIL abort_pre got acc=%0d en=%b i=%0d required 10 1 10",
               nacc, img_rd_en, res_idx);
    end
    ctrl_data = 32'h3;
    ctrl_wr   = 1'b1;
    @(negedge clk);
    ctrl_wr   = 1'b0;
    ctrl_data = 32'h0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_now got b=%b d=%b v=%b required 0 0 0",
               busy, done, res_valid);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || img_rd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet got %0d active cycles required 0", bad);
    end
    do_start();
    collect(0, -1);
    n_tests++;
    if (q_data.size() != NRES || q_idx[0] != 0 || done_c != 397) begin
      n_fail++;
      $display("FAIL abort_restart got n=%0d done@%0d required %0d 397",
               q_data.size(), done_c, NRES);
    end
    foreach (q_data[i]) begin
      n_tests++;
      if (q_data[i] !== model(i) || q_idx[i] != i) begin
        n_fail++;
        $display("FAIL abort_res got d=%h i=%0d required d=%h i=%0d",
                 q_data[i], q_idx[i], model(i), i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_start();
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({img_rd_en, img_rd_addr, res_valid, res_data, res_idx,
         busy, done, status} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got en=%b a=%0d v=%b d=%h b=%b required all 0",
               img_rd_en, img_rd_addr, res_valid, res_data, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (img_rd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_quiet got %0d active cycles required 0", bad);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ctrl_wr = 1'b0;
    ctrl_data = '0;
    filter1 = '0; filter2 = '0; filter3 = '0;
    res_ready = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_ones();
    test_ramp();
    test_negative();
    test_restart_busy();
    test_back_to_back_stall();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Sequencer for the 3x3 convolution engine behind the ICB register block. On a start command written to CONTROL, it walks every valid output position of an IMG_W x IMG_H 8-bit image held in the image buffer. For each position it issues nine buffer reads, multiplies each pixel by the matching coefficient unpacked from FILTER1..FILTER3, accumulates the products and hands the sum out over a valid/ready port. It reports busy/done status back to the register block for SUM readback.

## Interface
- IMG_W, 8: image width in pixels (≥3)
- IMG_H, 8: image height in pixels (≥3)
- ACC_W, 32: accumulator/result width
- AW, 6: image buffer address width, ≥ clog2(IMG_W*IMG_H)
- clk  in  1  clock; reset is asynchronous and active-low (rst_n), single clock domain
- rst_n  in  1  asynchronous active-low reset
- ctrl_wr  in  1  one-cycle pulse: CONTROL register written this cycle
- ctrl_data  in  32  value written; bit0 start, bit1 abort, others ignored
- filter1, filter2, filter3  in  32 each  coefficients, signed 8-bit, byte-packed; c0..c3 = filter1[7:0]..[31:24], c4..c7 = filter2 bytes, c8 = filter3[7:0]
- img_rd_en  out  1  image buffer read strobe
- img_rd_addr  out  AW  pixel address, row-major (row*IMG_W+col)
- img_rd_data  in  8  unsigned pixel, valid exactly 1 cycle after img_rd_en
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  ACC_W  signed convolution sum
- res_idx  out  16  linear output index (orow*(IMG_W-2)+ocol)
- busy  out  1  sequence in progress
- done  out  1  sticky; set on completion of the last result, cleared by next accepted start or reset
- status  out  32  {30'b0, done, busy}, wired to the SUM readback mux

## Operation
- FSM states: IDLE, FETCH, DRAIN, OUT.
- IDLE: if ctrl_wr & bit0 & !bit1, clear done, zero position counters (orow, ocol) and accumulator, go to FETCH.
- FETCH: 9 cycles with tap k = 0..8 (ky = k/3, kx = k%3). Drive img_rd_en=1 and addr=(orow+ky)*IMG_W+ocol+kx. Each cycle add the product of the previous tap's returned pixel and its coefficient. After tap 8, go to DRAIN.
- DRAIN: add the tap-8 product, go to OUT.
- OUT: res_valid=1, holding res_data/res_idx stable until res_valid&res_ready. On accept:
  - if this was the last position (orow=IMG_H-3, ocol=IMG_W-3), set done and go to IDLE;
  - else advance ocol, wrapping to 0 with orow+1 at IMG_W-3, clear the accumulator and go to FETCH.
- Arithmetic: pixel zero-extended to 9 bits signed × coef signed 8 → 17-bit signed product, sign-extended to ACC_W; wrap-around on overflow (no saturation).
- Coefficients are sampled live each tap. Software must not change FILTERx while busy (behaviour undefined, not an error).
- Abort (ctrl_wr & bit1) in any non-IDLE state: go to IDLE next cycle, drop res_valid, done stays 0, and any in-flight read data is ignored. Abort has priority over start when both bits are set.
- Start while busy: ignored.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, img_rd_en 0, img_rd_addr 0, res_valid 0, res_data 0, res_idx 0, busy 0, done 0, status 0.
- ctrl_wr start at cycle T → busy=1 and first img_rd_en at T+1.
- Per result with res_ready held high: 9 FETCH + 1 DRAIN + 1 OUT = 11 cycles. First res_valid at T+11.
- Full 8x8 run: 36 results, last accept at T+396, done=1 and busy=0 from T+397.
- All outputs registered. res_valid must not drop without a handshake except on abort or reset.

## Structure
- conv_pkg: FSM state enum, CTRL_START_BIT=0, CTRL_ABORT_BIT=1, tap count 9, STATUS bit positions.
- One sub-module, conv_mac: registered signed multiply-accumulate with clr/en inputs. The FSM, address generation and handshake stay in conv_seq_ctrl.

## Test plan
- All pixels 1, all coefs 1, 8x8 → 36 results, each 9; res_idx 0..35 in order; done at T+397.
- Pixel(r,c)=r*8+c, only c4=1 → result i equals pixel(orow+1, ocol+1); index 0 → 9, index 35 → 54.
- All pixels 255, all coefs -1 (0xFF) → every result -2295 (0xFFFFF709).
- res_ready toggled randomly, held low 20 cycles on result 5 → res_data/res_idx stable throughout, no result lost or duplicated.
- Abort on result 10 of FETCH → busy=0 next cycle, done=0, res_valid never asserted. A fresh start then completes normally with index 0 first.
- Start re-written while busy is ignored; rst_n asserted mid-FETCH → all outputs at reset values immediately, no reads until the next start.
